// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow sequencer: computes branch/JAL targets, issues the PC
// redirect and link write, then holds the front-end flush for FLUSH_CYCLES.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_cond,
  input  logic             stall,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      imm_in,
  output logic             jal_sel,
  output logic             redirect,
  output logic [31:0]      target,
  output logic             link_we,
  output logic [31:0]      link_addr,
  output logic             flush,
  output logic             busy,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]  state;
  logic [2:0]  flush_cnt;
  logic [31:0] sum;
  logic        take;
  logic        aligned;

  // The immediate generator needs the select in the same cycle, so no state term.
  assign jal_sel = ex_is_jal;

  assign sum     = ex_pc + imm_in;
  assign aligned = (sum[1:0] == 2'b00);
  // JAL overrides the branch condition when both decode bits are set.
  assign take    = ex_valid & ~stall & (state == IDLE) &
                   (ex_is_jal | (ex_is_branch & ex_cond));

  assign flush = (state == FLUSH);
  assign busy  = (state == FLUSH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= 3'd0;
      redirect  <= 1'b0;
      link_we   <= 1'b0;
      misalign  <= 1'b0;
      target    <= 32'd0;
      link_addr <= 32'd0;
      taken_cnt <= '0;
    end else begin
      redirect <= 1'b0;
      link_we  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (aligned) begin
              target    <= sum;
              redirect  <= 1'b1;
              flush_cnt <= 3'(FLUSH_CYCLES);
              taken_cnt <= taken_cnt + CNT_W'(1);
              state     <= FLUSH;
              if (ex_is_jal) begin
                link_addr <= ex_pc + 32'd4;
                link_we   <= 1'b1;
              end
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        FLUSH: begin
          // Wrong-path EX requests are ignored; stall does not pause the count.
          if (flush_cnt == 3'd1) begin
            flush_cnt <= 3'd0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second instance with CNT_W=4
// shares the stimulus to observe taken-counter wrap.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_cond, stall;
  logic [31:0] ex_pc, imm_in;

  logic        jal_sel, redirect, link_we, flush, busy, misalign;
  logic [31:0] target, link_addr;
  logic [15:0] taken_cnt;

  logic        s_jal_sel, s_redirect, s_link_we, s_flush, s_busy, s_misalign;
  logic [31:0] s_target, s_link_addr;
  logic [3:0]  s_taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_cond(ex_cond), .stall(stall), .ex_pc(ex_pc),
    .imm_in(imm_in), .jal_sel(jal_sel), .redirect(redirect), .target(target),
    .link_we(link_we), .link_addr(link_addr), .flush(flush), .busy(busy),
    .misalign(misalign), .taken_cnt(taken_cnt)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_cond(ex_cond), .stall(stall), .ex_pc(ex_pc),
    .imm_in(imm_in), .jal_sel(s_jal_sel), .redirect(s_redirect), .target(s_target),
    .link_we(s_link_we), .link_addr(s_link_addr), .flush(s_flush), .busy(s_busy),
    .misalign(s_misalign), .taken_cnt(s_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_cond = 1'b0;
    stall = 1'b0; ex_pc = 32'd0; imm_in = 32'd0;
  endtask

  task automatic drive(input logic br, input logic jal, input logic cond,
                       input logic [31:0] pc, input logic [31:0] imm);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jal = jal; ex_cond = cond;
    ex_pc = pc; imm_in = imm;
  endtask

  // One taken branch, then wait out the 2-cycle flush.
  task automatic redirect_and_drain(input logic [31:0] pc);
    drive(1'b1, 1'b0, 1'b1, pc, 32'h10);
    step();
    clear_ex();
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_ex();
    #12;
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_target", target, 32'h0);
    check("rst_link", link_addr, 32'h0);
    check("rst_cnt", 32'(taken_cnt), 32'h0);
    check("rst_small", {s_jal_sel, s_redirect, s_link_we, s_flush, s_busy, s_misalign,
                        s_target[1:0], s_link_addr[1:0], s_taken_cnt}, 32'h0);
    reset = 1'b0;

    // Taken BEQ, backward offset.
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0);
    #1 check("beq_jal_sel", 32'(jal_sel), 32'h0);
    step();
    clear_ex();
    check("beq_redirect", 32'(redirect), 32'h1);
    check("beq_target", target, 32'h0000_00F0);
    check("beq_link_we", 32'(link_we), 32'h0);
    check("beq_flush1", 32'(flush), 32'h1);
    check("beq_busy1", 32'(busy), 32'h1);
    check("beq_cnt", 32'(taken_cnt), 32'h1);
    step();
    check("beq_redirect_pulse", 32'(redirect), 32'h0);
    check("beq_flush2", 32'(flush), 32'h1);
    step();
    check("beq_flush3", 32'(flush), 32'h0);
    check("beq_busy3", 32'(busy), 32'h0);

    // JAL, with a taken branch presented while flushing.
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0000_0800);
    #1 check("jal_sel", 32'(jal_sel), 32'h1);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h10);
    check("jal_redirect", 32'(redirect), 32'h1);
    check("jal_target", target, 32'h0000_0A00);
    check("jal_link_addr", link_addr, 32'h0000_0204);
    check("jal_link_we", 32'(link_we), 32'h1);
    check("jal_cnt", 32'(taken_cnt), 32'h2);
    step();
    check("fl_link_we_pulse", 32'(link_we), 32'h0);
    check("fl_redirect", 32'(redirect), 32'h0);
    check("fl_flush", 32'(flush), 32'h1);
    step();
    clear_ex();
    check("fl_ignored", 32'(redirect), 32'h0);
    check("fl_done", 32'(flush), 32'h0);
    check("fl_cnt", 32'(taken_cnt), 32'h2);
    check("fl_target_hold", target, 32'h0000_0A00);

    // Branch not taken.
    drive(1'b1, 1'b0, 1'b0, 32'h300, 32'h10);
    step();
    clear_ex();
    check("nt_redirect", 32'(redirect), 32'h0);
    check("nt_flush", 32'(flush), 32'h0);
    check("nt_misalign", 32'(misalign), 32'h0);
    check("nt_cnt", 32'(taken_cnt), 32'h2);

    // Stall holds a taken branch for 3 cycles.
    drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_redirect", 32'(redirect), 32'h0);
      check("stall_flush", 32'(flush), 32'h0);
    end
    stall = 1'b0;
    step();
    clear_ex();
    check("unstall_redirect", 32'(redirect), 32'h1);
    check("unstall_target", target, 32'h0000_0420);
    check("unstall_cnt", 32'(taken_cnt), 32'h3);
    step();
    step();

    // Misaligned target.
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h6);
    step();
    clear_ex();
    check("mis_misalign", 32'(misalign), 32'h1);
    check("mis_redirect", 32'(redirect), 32'h0);
    check("mis_flush", 32'(flush), 32'h0);
    check("mis_cnt", 32'(taken_cnt), 32'h3);
    check("mis_target_hold", target, 32'h0000_0420);
    step();
    check("mis_pulse", 32'(misalign), 32'h0);

    // Address wrap-around on target and link.
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8);
    step();
    clear_ex();
    check("wrap_target", target, 32'h0000_0004);
    check("wrap_link", link_addr, 32'h0000_0000);
    check("wrap_cnt", 32'(taken_cnt), 32'h4);
    step();
    step();

    // Twelve more redirects: 16 total, so the 4-bit counter wraps to zero.
    for (int i = 0; i < 12; i++) redirect_and_drain(32'h1000 + 32'(i) * 32'h40);
    check("cntw_main", 32'(taken_cnt), 32'd16);
    check("cntw_small", 32'(s_taken_cnt), 32'd0);

    // Asynchronous reset in the middle of a flush.
    drive(1'b0, 1'b1, 1'b0, 32'h800, 32'h40);
    step();
    clear_ex();
    check("pre_rst_flush", 32'(flush), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_redirect", 32'(redirect), 32'h0);
    check("arst_link_we", 32'(link_we), 32'h0);
    check("arst_flush", 32'(flush), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_target", target, 32'h0);
    check("arst_link", link_addr, 32'h0);
    check("arst_cnt", 32'(taken_cnt), 32'h0);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h500, 32'h100);
    step();
    clear_ex();
    check("post_redirect", 32'(redirect), 32'h1);
    check("post_target", target, 32'h0000_0600);
    check("post_link", link_addr, 32'h0000_0504);
    check("post_cnt", 32'(taken_cnt), 32'h1);
    step();
    step();
    check("post_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow changes for the 32-bit RISC-V pipeline at the EX stage.
- Drives the Jal select of the immediate generator, consumes its sign-extended offset and computes the branch/JAL target (pc + imm).
- Issues a one-cycle PC redirect, writes the JAL link address, and holds the front-end flush for a fixed number of cycles while squashing wrong-path instructions.
- Sits between the EX stage, the PC register/fetch mux and the IF/ID and ID/EX pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7).
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX stage holds a valid, non-squashed instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_is_jal  input  1  EX instruction is JAL.
- ex_cond  input  1  branch condition result from the ALU comparator.
- stall  input  1  pipeline stall from the hazard unit; EX contents are not final.
- ex_pc  input  32  PC of the EX instruction.
- imm_in  input  32  sign-extended offset from the immediate generator.
- jal_sel  output  1  Jal select to the immediate generator (combinational).
- redirect  output  1  one-cycle pulse; the PC mux must load target.
- target  output  32  registered redirect target.
- link_we  output  1  one-cycle pulse; write link_addr to rd.
- link_addr  output  32  registered ex_pc + 4 of the JAL.
- flush  output  1  squash the IF/ID and ID/EX registers.
- busy  output  1  controller is in the FLUSH state.
- misalign  output  1  one-cycle pulse; computed target[1:0] is not 00.
- taken_cnt  output  CNT_W  count of redirects issued; wraps.

Behaviour:
- Reset (asynchronous, active-high) applies in any state:
  - State goes to IDLE.
  - redirect, link_we, flush, busy and misalign go to 0.
  - target, link_addr and taken_cnt go to 0.
  - The flush counter goes to 0.
  - Reset during FLUSH abandons the flush immediately.
- jal_sel = ex_is_jal. This is purely combinational, with no dependence on state, so the immediate is valid in the same cycle.
- take = ex_valid & ~stall & state==IDLE & (ex_is_jal | (ex_is_branch & ex_cond)).
- If ex_is_jal and ex_is_branch are both 1, JAL wins: the redirect is unconditional and jal_sel=1.
- sum = ex_pc + imm_in, modulo 2^32. Wrap-around is silent.
- IDLE:
  - If take and sum[1:0]==00: on the next edge, register target=sum and assert redirect=1 for one cycle.
  - In that same case, if JAL, also register link_addr=ex_pc+4 and assert link_we=1 for one cycle.
  - In that same case, set flush=1, busy=1, load the counter with FLUSH_CYCLES, increment taken_cnt, and go to FLUSH.
  - If take and sum[1:0]!=00: assert misalign=1 for one cycle. No redirect, no link write, no flush, and taken_cnt is unchanged. Stay in IDLE.
  - A not-taken branch produces no output activity.
- Latency: request sampled at edge N gives redirect, link_we and target valid in cycle N+1. flush is high for cycles N+1 .. N+FLUSH_CYCLES inclusive.
- FLUSH:
  - The counter decrements each edge; flush and busy stay 1.
  - When the counter reaches 1, the next edge clears flush and busy and returns to IDLE.
  - All EX requests are ignored in FLUSH because they are wrong-path.
  - stall does not pause the flush count.
- stall=1 in IDLE: the request is not latched. It is re-evaluated each cycle until stall drops.
- target and link_addr hold their last values between redirects.
- redirect and link_we never assert in consecutive cycles.

Test Plan:
- Reset is asserted mid-FLUSH, asynchronously between edges -> all outputs drop to 0 immediately. A JAL after release redirects normally.
- Taken BEQ: ex_pc=0x100, imm_in=0xFFFFFFF0 (−16), ex_cond=1 -> next cycle redirect=1 and target=0x000000F0, with link_we=0. flush is high exactly 2 cycles and taken_cnt=1.
- JAL: ex_pc=0x200, imm_in=0x00000800 -> jal_sel=1 in the same cycle. Next cycle target=0xA00, link_addr=0x204 and link_we=1 for one cycle.
- Taken branch during FLUSH, and a branch with ex_cond=0 in IDLE -> no redirect and taken_cnt unchanged.
- stall=1 for 3 cycles with a taken branch held in EX -> no redirect while stalled. A single redirect occurs one cycle after stall falls.
- Misaligned target: ex_pc=0x100, imm_in=0x6 -> misalign=1 for one cycle, with redirect=0, flush=0 and taken_cnt unchanged.
- Wrap-around: ex_pc=0xFFFFFFFC, imm_in=0x8 -> target=0x00000004.
- Counter wrap: with CNT_W=4, 16 redirects -> taken_cnt=0.
